// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, default
// parameter values and the round-robin pointer helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ACTIVE,
    S_GAP,
    S_HOLD
  } state_e;

  localparam int unsigned DefNumReq        = 4;
  localparam int unsigned DefGapCycles     = 0;
  localparam int unsigned DefLaunchTimeout = 16;

  // Next requester index after idx, wrapping at n.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward
// from ptr, wrapping modulo NumReq.
module uart_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx,
  output logic              found
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr) + i) % NumReq);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between several byte-stream requesters with round-robin
// arbitration, packet locking, launch timeout and a programmable inter-frame gap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned p_num_req        = DefNumReq,
  parameter int unsigned p_gap_cycles     = DefGapCycles,
  parameter int unsigned p_launch_timeout = DefLaunchTimeout
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [p_num_req-1:0]   req_valid_i,
  input  logic [8*p_num_req-1:0] req_data_i,
  input  logic [p_num_req-1:0]   req_last_i,
  output logic [p_num_req-1:0]   req_ready_o,
  output logic                   tx_enable_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_busy_i,
  output logic [p_num_req-1:0]   grant_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned IdxW = $clog2(p_num_req);
  localparam int unsigned GapW = (p_gap_cycles > 0) ? $clog2(p_gap_cycles + 1) : 1;
  localparam int unsigned ToW  = (p_launch_timeout > 0) ? $clog2(p_launch_timeout + 1) : 1;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [7:0]           data_q, data_d;
  logic                 lock_end_q, lock_end_d;
  logic [p_num_req-1:0] grant_q, grant_d;
  logic                 err_q, err_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;

  logic [p_num_req-1:0] arb_gnt;
  logic [IdxW-1:0]      arb_idx;
  logic                 arb_found;
  logic [IdxW-1:0]      sel_idx;
  logic [7:0]           sel_data;
  logic                 sel_last;
  logic                 gap_done;
  logic                 launch_expired;
  logic                 frame_exit;
  logic [IdxW-1:0]      owner_next;

  uart_rr_arbiter #(
    .NumReq (p_num_req),
    .IdxW   (IdxW)
  ) u_arbiter (
    .req   (req_valid_i),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // In S_HOLD only the owner may transfer; elsewhere the arbiter picks.
  assign sel_idx        = (state_q == S_HOLD) ? owner_q : arb_idx;
  assign sel_data       = req_data_i[{sel_idx, 3'b000} +: 8];
  assign sel_last       = req_last_i[sel_idx];
  assign gap_done       = (32'(gap_cnt_q) + 32'd1) >= p_gap_cycles;
  assign launch_expired = (32'(to_cnt_q) + 32'd1) >= p_launch_timeout;
  assign owner_next     = IdxW'(rr_next(32'(owner_q), p_num_req));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    data_d      = data_q;
    lock_end_d  = lock_end_q;
    grant_d     = grant_q;
    err_d       = err_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    req_ready_o = '0;
    tx_enable_o = 1'b0;
    frame_exit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          req_ready_o = arb_gnt;
          data_d      = sel_data;
          lock_end_d  = sel_last;
          grant_d     = arb_gnt;
          owner_d     = arb_idx;
          to_cnt_d    = '0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tx_enable_o = 1'b1;
        if (tx_busy_i) begin
          state_d = S_ACTIVE;
        end else if (launch_expired) begin
          // Transmitter never answered: drop the byte and release the lock.
          err_d    = 1'b1;
          grant_d  = '0;
          rr_ptr_d = owner_next;
          state_d  = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!tx_busy_i) begin
          if (p_gap_cycles == 0) begin
            frame_exit = 1'b1;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_done) begin
          frame_exit = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        req_ready_o[owner_q] = req_valid_i[owner_q];
        if (req_valid_i[owner_q]) begin
          data_d     = sel_data;
          lock_end_d = sel_last;
          to_cnt_d   = '0;
          state_d    = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_exit) begin
      if (lock_end_q) begin
        grant_d  = '0;
        rr_ptr_d = owner_next;
        state_d  = S_IDLE;
      end else begin
        state_d = S_HOLD;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      data_q     <= 8'h00;
      lock_end_q <= 1'b0;
      grant_q    <= '0;
      err_q      <= 1'b0;
      gap_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      data_q     <= data_d;
      lock_end_q <= lock_end_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      gap_cnt_q  <= gap_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign tx_data_o = data_q;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: per-cycle vector table, directed
// timeout / reset sequences and packet-level scoreboarded random traffic.
module tb_uart_tx_scheduler;

  localparam int unsigned NR  = 4;
  localparam int unsigned GAP = 5;
  localparam int unsigned TO  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_enable;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .p_num_req        (NR),
    .p_gap_cycles     (GAP),
    .p_launch_timeout (TO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_enable_o (tx_enable),
    .tx_data_o   (tx_data),
    .tx_busy_i   (tx_busy),
    .grant_o     (grant),
    .busy_o      (busy),
    .err_o       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Per-cycle vectors: inputs applied at the negedge, outputs checked 1 time unit later.
  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        bsy;
    logic [3:0]  rdy;
    logic        en;
    logic [7:0]  txd;
    logic [3:0]  gnt;
    logic        bo;
    logic        er;
  } vec_t;

  function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic b,
                              logic [3:0] r, logic e, logic [7:0] t, logic [3:0] g,
                              logic bo, logic er);
    vec_t x;
    x.valid = v; x.data = d; x.last = l; x.bsy = b;
    x.rdy = r; x.en = e; x.txd = t; x.gnt = g; x.bo = bo; x.er = er;
    return x;
  endfunction

  // Packet workload: bit 8 marks the last byte of a packet.
  logic [8:0] mem [NR][64];
  int         head [NR];
  int         tail [NR];
  logic [9:0] exp_q [$];

  // Packet-level reference: whole packets, owner chosen round-robin from ptr.
  task automatic build_expected();
    int h [NR];
    int ptr;
    int w;
    int j;
    ptr = 0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) h[i] = head[i];
    while (1) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        j = (ptr + k) % NR;
        if (w < 0 && h[j] < tail[j]) w = j;
      end
      if (w < 0) break;
      do begin
        exp_q.push_back({2'(w), mem[w][h[w]][7:0]});
        h[w]++;
      end while (!mem[w][h[w]-1][8]);
      ptr = (w + 1) % NR;
    end
  endtask

  task automatic clear_work();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input logic l);
    mem[r][tail[r]] = {l, b};
    tail[r]++;
  endtask

  task automatic gen_random();
    int np;
    int len;
    clear_work();
    for (int i = 0; i < NR; i++) begin
      np = $urandom_range(i == 0 ? 1 : 0, 3);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
      end
    end
  endtask

  // Runs the workload against a behavioural uart_tx model and scoreboards it.
  task automatic run_traffic(input string tag, input int max_cyc);
    int         n = 0;
    logic       ubusy = 1'b0;
    int         left = 0;
    logic       en_prev = 1'b0;
    int         en_run = 0;
    int         fall_cyc = -1;
    int         xfers = 0;
    logic [7:0] want_byte = 8'h00;
    logic [1:0] want_req = 2'd0;
    logic [9:0] e;
    bit         done = 1'b0;
    build_expected();
    while (!done) begin
      // uart_tx registers enable at the edge, then stays busy for a frame
      if (ubusy) begin
        left--;
        if (left == 0) begin
          ubusy    = 1'b0;
          fall_cyc = n;
        end
      end else if (en_prev) begin
        ubusy = 1'b1;
        left  = $urandom_range(3, 12);
      end
      tx_busy = ubusy;
      for (int i = 0; i < NR; i++) begin
        if (head[i] < tail[i]) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = mem[i][head[i]][7:0];
          req_last[i]       = mem[i][head[i]][8];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i]       = 1'($urandom);
        end
      end
      #1;
      chk({tag, " ready legal"},
          32'($countones(req_ready) <= 1 && (req_ready & ~req_valid) == '0), 32'd1);
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (exp_q.size() == 0) begin
            chk({tag, " unexpected transfer"}, 32'(i), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk({tag, " served requester"}, 32'(i), 32'(e[9:8]));
            want_byte = e[7:0];
            want_req  = e[9:8];
          end
          if (xfers > 0) chk({tag, " gap timing"}, 32'(n), 32'(fall_cyc + GAP + 1));
          head[i]++;
          xfers++;
        end
      end
      if (tx_enable && !en_prev) begin
        chk({tag, " launch data"}, 32'(tx_data), 32'(want_byte));
        chk({tag, " launch grant"}, 32'(grant), 32'(4'b0001 << want_req));
      end
      if (tx_enable) en_run++;
      if (!tx_enable && en_prev) begin
        chk({tag, " enable length"}, 32'(en_run), 32'd2);
        en_run = 0;
      end
      if (ubusy) chk({tag, " data held"}, 32'(tx_data), 32'(want_byte));
      en_prev = tx_enable;
      n++;
      if (exp_q.size() == 0 && !busy && !ubusy && xfers > 0) begin
        done = 1'b1;
      end else if (n >= max_cyc) begin
        checks++;
        failures++;
        $display("FAIL %s cycle budget: actual=%0d required<%0d", tag, n, max_cyc);
        done = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, " all bytes served"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " no error"}, 32'(err), 32'd0);
  endtask

  vec_t vt [13];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    @(negedge clk);
    #1;
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset enable", 32'(tx_enable), 32'd0);
    chk("reset data", 32'(tx_data), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte A5 from req0, then req1 waits out the gap and wins via rr_ptr = 1.
    vt[0]  = mk(4'b0001, 32'h0000_00A5, 4'b0001, 0, 4'b0001, 0, 8'h00, 4'b0000, 0, 0);
    vt[1]  = mk(4'b0000, 32'hFFFF_FFFF, 4'b0000, 0, 4'b0000, 1, 8'hA5, 4'b0001, 1, 0);
    vt[2]  = mk(4'b0000, 32'hFFFF_FFFF, 4'b0000, 1, 4'b0000, 1, 8'hA5, 4'b0001, 1, 0);
    vt[3]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 8'hA5, 4'b0001, 1, 0);
    vt[4]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 8'hA5, 4'b0001, 1, 0);
    vt[5]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'hA5, 4'b0001, 1, 0);
    for (int i = 6; i <= 10; i++)
      vt[i] = mk(4'b0010, 32'h0000_3C00, 4'b0010, 0, 4'b0000, 0, 8'hA5, 4'b0001, 1, 0);
    vt[11] = mk(4'b0010, 32'h0000_3C00, 4'b0010, 0, 4'b0010, 0, 8'hA5, 4'b0000, 0, 0);
    vt[12] = mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 1, 8'h3C, 4'b0010, 1, 0);
    for (int i = 0; i < 13; i++) begin
      req_valid = vt[i].valid;
      req_data  = vt[i].data;
      req_last  = vt[i].last;
      tx_busy   = vt[i].bsy;
      #1;
      chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vt[i].rdy));
      chk($sformatf("vec%0d enable", i), 32'(tx_enable), 32'(vt[i].en));
      chk($sformatf("vec%0d data", i), 32'(tx_data), 32'(vt[i].txd));
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vt[i].gnt));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].bo));
      chk($sformatf("vec%0d err", i), 32'(err), 32'(vt[i].er));
      @(negedge clk);
    end

    // Launch timeout: transmitter never asserts busy.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h005A_0000;
    req_last  = 4'b0100;
    #1;
    chk("timeout ready", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid = '0;
    for (int i = 1; i <= TO; i++) begin
      #1;
      chk($sformatf("timeout launch%0d enable", i), 32'(tx_enable), 32'd1);
      chk($sformatf("timeout launch%0d err", i), 32'(err), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("timeout err set", 32'(err), 32'd1);
    chk("timeout grant", 32'(grant), 32'd0);
    chk("timeout busy", 32'(busy), 32'd0);
    req_valid = 4'b1001;
    req_data  = 32'h7E00_0081;
    req_last  = 4'b1001;
    #1;
    chk("timeout next winner", 32'(req_ready), 32'(4'b1000));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("timeout next grant", 32'(grant), 32'(4'b1000));
    chk("timeout next data", 32'(tx_data), 32'h7E);
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    #1;
    chk("timeout next active enable", 32'(tx_enable), 32'd0);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    #1;
    chk("timeout next done", 32'(busy), 32'd0);
    chk("timeout err sticky", 32'(err), 32'd1);

    // Asynchronous reset during requester 2's frame.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h00C3_0000;
    req_last  = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset pre grant", 32'(grant), 32'(4'b0100));
    chk("midreset pre data", 32'(tx_data), 32'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset ready", 32'(req_ready), 32'd0);
    chk("midreset enable", 32'(tx_enable), 32'd0);
    chk("midreset data", 32'(tx_data), 32'd0);
    chk("midreset grant", 32'(grant), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset err", 32'(err), 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0101;
    req_data  = 32'h0011_0022;
    req_last  = 4'b0101;
    #1;
    chk("midreset rr restart", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);

    // Packet lock: req1 sends 11,22,33 while req2 waits.
    do_reset();
    clear_work();
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    push_byte(2, 8'h44, 1'b1);
    run_traffic("lock", 500);

    // Round-robin: three single-byte packets from every requester.
    do_reset();
    clear_work();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < NR; i++) push_byte(i, {4'(i), 4'(p)}, 1'b1);
    run_traffic("rr", 1500);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      gen_random();
      run_traffic($sformatf("rand%0d", r), 4000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
